// File: rtl/window_pkg.sv
// Shared codes and helpers for the window firing FSM and its reduction datapath.
package window_pkg;

    // Mode select codes presented on next_mode_in; code 3 is invalid.
    localparam logic [1:0] MODE_LOAD   = 2'd0;
    localparam logic [1:0] MODE_COMP   = 2'd1;
    localparam logic [1:0] MODE_OUTPUT = 2'd2;

    // Reduction command codes presented on command_in.
    localparam logic [1:0] CMD_SUM    = 2'd0;
    localparam logic [1:0] CMD_MAX    = 2'd1;
    localparam logic [1:0] CMD_MIN    = 2'd2;
    localparam logic [1:0] CMD_ABSSUM = 2'd3;

    // State encoding.
    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] ST_START  = 3'd0;
    localparam logic [StateW-1:0] ST_LOAD   = 3'd1;
    localparam logic [StateW-1:0] ST_COMP   = 3'd2;
    localparam logic [StateW-1:0] ST_OUTPUT = 3'd3;
    localparam logic [StateW-1:0] ST_END    = 3'd4;

    typedef enum logic [StateW-1:0] {
        StStart  = ST_START,
        StLoad   = ST_LOAD,
        StComp   = ST_COMP,
        StOutput = ST_OUTPUT,
        StEnd    = ST_END
    } state_e;

    // Ceiling log2, never below 1 so that derived vector widths stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/window_firing_fsm_v2_reduce_step.sv
// Combinational single-element reduction step plus saturation of the next accumulator.
module window_reduce_step
    import window_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned AW    = 13
) (
    input  logic signed [AW-1:0]    acc_i,
    input  logic signed [WIDTH-1:0] elem_i,
    input  logic [1:0]              cmd_i,
    input  logic                    first_i,
    output logic signed [AW-1:0]    acc_o,
    output logic signed [WIDTH-1:0] sat_o
);

    // Signed WIDTH-range limits, sign-extended to the accumulator width.
    localparam logic signed [AW-1:0] SatMax = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic signed [AW-1:0] elem_w;
    logic signed [AW-1:0] abs_w;

    // Widen the element first so abs(most-negative) cannot overflow.
    always_comb begin
        elem_w = {{(AW - WIDTH){elem_i[WIDTH-1]}}, elem_i};
        abs_w  = elem_w[AW-1] ? -elem_w : elem_w;
    end

    // Next accumulator; the first element seeds max/min and restarts the sums.
    always_comb begin
        acc_o = acc_i;
        case (cmd_i)
            CMD_SUM:    acc_o = first_i ? elem_w : acc_i + elem_w;
            CMD_MAX:    acc_o = (first_i || (elem_w > acc_i)) ? elem_w : acc_i;
            CMD_MIN:    acc_o = (first_i || (elem_w < acc_i)) ? elem_w : acc_i;
            CMD_ABSSUM: acc_o = first_i ? abs_w : acc_i + abs_w;
            default:    acc_o = acc_i;
        endcase
    end

    // Clamp the next accumulator into the signed WIDTH range.
    always_comb begin
        if (acc_o > SatMax) begin
            sat_o = SatMax[WIDTH-1:0];
        end else if (acc_o < SatMin) begin
            sat_o = SatMin[WIDTH-1:0];
        end else begin
            sat_o = acc_o[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/window_firing_fsm_v2.sv
// Window-computation firing FSM: one LOAD, COMP or OUTPUT mode per start_in request.
module window_firing_fsm_v2
    import window_pkg::*;
#(
    parameter  int unsigned SIZE  = 3,
    parameter  int unsigned WIDTH = 10,
    localparam int unsigned LW    = clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [1:0]       next_mode_in,
    input  logic [LW-1:0]    length_in,
    input  logic [1:0]       command_in,
    input  logic [WIDTH-1:0] data_in_fifo,
    input  logic             in_fifo_empty,
    input  logic             out_fifo_full,
    output logic             rd_in_data_fifo,
    output logic             wr_out_fifo1,
    output logic [WIDTH-1:0] data_out,
    output logic             done_out,
    output logic             err_out
);

    localparam int unsigned IW = clog2(SIZE);
    localparam int unsigned AW = WIDTH + clog2(SIZE) + 1;

    localparam logic [LW-1:0] SizeL   = LW'(SIZE);
    localparam logic [IW-1:0] LastIdx = IW'(SIZE - 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [WIDTH-1:0] res_q, res_d;
    logic [LW-1:0]           len_q, len_d;
    logic [1:0]              cmd_q, cmd_d;
    logic                    err_q, err_d;
    logic signed [WIDTH-1:0] mem_q [SIZE];

    logic                    mem_we;
    logic [LW-1:0]           len_eff;
    logic                    comp_first;
    logic                    comp_last;
    logic                    load_last;
    logic signed [WIDTH-1:0] cur_elem;
    logic signed [AW-1:0]    mem0_ext;
    logic signed [AW-1:0]    step_acc;
    logic signed [WIDTH-1:0] step_sat;

    // Window length clamp and position decode for the running index.
    always_comb begin
        len_eff    = ((len_q == '0) || (len_q > SizeL)) ? SizeL : len_q;
        comp_first = (idx_q == '0);
        comp_last  = ((LW'(idx_q) + LW'(1)) == len_eff);
        load_last  = (idx_q == LastIdx);
        cur_elem   = mem_q[idx_q];
        mem0_ext   = {{(AW - WIDTH){mem_q[0][WIDTH-1]}}, mem_q[0]};
    end

    window_reduce_step #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_step (
        .acc_i   (acc_q),
        .elem_i  (cur_elem),
        .cmd_i   (cmd_q),
        .first_i (comp_first),
        .acc_o   (step_acc),
        .sat_o   (step_sat)
    );

    // Next-state, datapath updates and outputs; FIFO enables are gated by the live flags.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        acc_d           = acc_q;
        res_d           = res_q;
        len_d           = len_q;
        cmd_d           = cmd_q;
        err_d           = 1'b0;
        mem_we          = 1'b0;
        rd_in_data_fifo = 1'b0;
        wr_out_fifo1    = 1'b0;
        done_out        = 1'b0;

        unique case (state_q)
            StStart: begin
                if (start_in) begin
                    len_d = length_in;
                    cmd_d = command_in;
                    idx_d = '0;
                    case (next_mode_in)
                        MODE_LOAD: begin
                            state_d = StLoad;
                        end
                        MODE_COMP: begin
                            state_d = StComp;
                            acc_d   = ((command_in == CMD_MAX) || (command_in == CMD_MIN)) ?
                                      mem0_ext : '0;
                        end
                        MODE_OUTPUT: begin
                            state_d = StOutput;
                        end
                        default: begin
                            // Invalid mode: report through END without touching memory/result.
                            state_d = StEnd;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            StLoad: begin
                rd_in_data_fifo = !in_fifo_empty;
                if (!in_fifo_empty) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + IW'(1);
                    if (load_last) begin
                        idx_d   = '0;
                        state_d = StEnd;
                    end
                end
            end
            StComp: begin
                acc_d = step_acc;
                idx_d = idx_q + IW'(1);
                if (comp_last) begin
                    idx_d   = '0;
                    res_d   = step_sat;
                    state_d = StEnd;
                end
            end
            StOutput: begin
                wr_out_fifo1 = !out_fifo_full;
                if (!out_fifo_full) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                done_out = 1'b1;
                state_d  = StStart;
            end
            default: begin
                state_d = StStart;
            end
        endcase
    end

    // Moore outputs driven straight from registers.
    always_comb begin
        data_out = res_q;
        err_out  = err_q;
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StStart;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            len_q   <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            len_q   <= len_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
        end
    end

    // Local token memory, written only by accepted LOAD reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= data_in_fifo;
        end
    end

endmodule

// File: tb/tb_window_firing_fsm_v2.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks.
module tb_window_firing_fsm_v2;

    localparam int SIZE  = 4;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic [1:0] next_mode_in = 2'd0;
    logic [2:0] length_in = 3'd0;
    logic [1:0] command_in = 2'd0;
    logic [7:0] data_in_fifo = 8'd0;
    logic       in_fifo_empty = 1'b1;
    logic       out_fifo_full = 1'b0;
    logic       rd_in_data_fifo;
    logic       wr_out_fifo1;
    logic [7:0] data_out;
    logic       done_out;
    logic       err_out;

    window_firing_fsm_v2 #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .next_mode_in    (next_mode_in),
        .length_in       (length_in),
        .command_in      (command_in),
        .data_in_fifo    (data_in_fifo),
        .in_fifo_empty   (in_fifo_empty),
        .out_fifo_full   (out_fifo_full),
        .rd_in_data_fifo (rd_in_data_fifo),
        .wr_out_fifo1    (wr_out_fifo1),
        .data_out        (data_out),
        .done_out        (done_out),
        .err_out         (err_out)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_rd = 0, n_wr = 0, n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_asserts++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {PhIdle, PhLoad, PhComp, PhOut, PhDone} phase_t;
    phase_t m_ph = PhIdle;
    int     m_mem[SIZE];
    int     m_result = 0;
    int     m_loaded = 0;
    int     m_comp_left = 0;
    int     m_pending = 0;
    bit     m_err = 1'b0;

    function automatic int eff_len(input int l);
        return ((l == 0) || (l > SIZE)) ? SIZE : l;
    endfunction

    function automatic int model_reduce(input int le, input int c);
        int acc;
        acc = ((c == 1) || (c == 2)) ? m_mem[0] : 0;
        for (int i = 0; i < le; i++) begin
            int v;
            v = m_mem[i];
            case (c)
                0:       acc += v;
                1:       if (v > acc) acc = v;
                2:       if (v < acc) acc = v;
                default: acc += (v < 0) ? -v : v;
            endcase
        end
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    task automatic model_reset();
        m_ph = PhIdle;
        m_result = 0;
        m_loaded = 0;
        m_comp_left = 0;
        m_err = 1'b0;
        for (int i = 0; i < SIZE; i++) m_mem[i] = 0;
    endtask

    task automatic model_step();
        case (m_ph)
            PhIdle: begin
                if (start_in) begin
                    case (next_mode_in)
                        2'd0: begin m_ph = PhLoad; m_loaded = 0; end
                        2'd1: begin
                            m_comp_left = eff_len(int'(length_in));
                            m_pending = model_reduce(m_comp_left, int'(command_in));
                            m_ph = PhComp;
                        end
                        2'd2: m_ph = PhOut;
                        default: begin m_ph = PhDone; m_err = 1'b1; end
                    endcase
                end
            end
            PhLoad: begin
                if (!in_fifo_empty) begin
                    m_mem[m_loaded] = int'($signed(data_in_fifo));
                    m_loaded++;
                    if (m_loaded == SIZE) m_ph = PhDone;
                end
            end
            PhComp: begin
                m_comp_left--;
                if (m_comp_left == 0) begin
                    m_result = m_pending;
                    m_ph = PhDone;
                end
            end
            PhOut: if (!out_fifo_full) m_ph = PhDone;
            default: begin m_ph = PhIdle; m_err = 1'b0; end
        endcase
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) m_mem[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) model_step();
        end
    end

    initial forever begin
        @(negedge rst);
        model_reset();
    end

    // Compare process: every cycle out of reset, outputs against the model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rd_in_data_fifo", int'(rd_in_data_fifo),
                  int'((m_ph == PhLoad) && !in_fifo_empty));
            check("wr_out_fifo1", int'(wr_out_fifo1), int'((m_ph == PhOut) && !out_fifo_full));
            check("done_out", int'(done_out), int'(m_ph == PhDone));
            check("err_out", int'(err_out), int'((m_ph == PhDone) && m_err));
            check("data_out", int'($signed(data_out)), m_result);
            if (rd_in_data_fifo) n_rd++;
            if (wr_out_fifo1)    n_wr++;
            if (err_out)         n_err++;
        end
    end

    // ---------------- input FIFO and full-flag drivers ----------------
    logic [7:0] fifo_q[$];
    bit gap_en = 1'b0, rand_gap = 1'b0, rand_full = 1'b0, noise_en = 1'b0;
    int full_left = 0;

    initial begin
        bit pop;
        bit odd;
        odd = 1'b0;
        forever begin
            @(negedge clk);
            pop = rd_in_data_fifo;
            @(posedge clk);
            #2;
            if (pop && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
            odd = !odd;
            in_fifo_empty = (fifo_q.size() == 0) || (gap_en && odd) ||
                            (rand_gap && ($urandom_range(0, 2) == 0));
            data_in_fifo = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        if (full_left > 0) begin
            out_fifo_full = 1'b1;
            full_left--;
        end else begin
            out_fifo_full = rand_full && ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        fifo_q.push_back(c);
        fifo_q.push_back(d);
    endtask

    // Fire one mode; lat = cycles from dispatch edge to the done_out cycle (0 on timeout).
    task automatic fire(input logic [1:0] m, input logic [2:0] l, input logic [1:0] c,
                        output int lat);
        @(posedge clk);
        #2;
        start_in = 1'b1;
        next_mode_in = m;
        length_in = l;
        command_in = c;
        @(posedge clk);
        #2;
        start_in = 1'b0;
        length_in = 3'($urandom);
        command_in = 2'($urandom);
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            #1;
            if (done_out) begin
                lat = k;
                break;
            end
            if (noise_en) begin
                start_in = 1'($urandom_range(0, 1));
                next_mode_in = 2'($urandom);
            end
        end
        start_in = 1'b0;
        check("done_within_bound", int'(lat != 0), 1);
    endtask

    function automatic logic [7:0] rand_token();
        case ($urandom_range(0, 3))
            0:       return 8'h7F;
            1:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        #2 rst = 1'b0;
        #1;
        check("reset_rd", int'(rd_in_data_fifo), 0);
        check("reset_wr", int'(wr_out_fifo1), 0);
        check("reset_done", int'(done_out), 0);
        check("reset_err", int'(err_out), 0);
        check("reset_data_out", int'(data_out), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // LOAD 5,-3,7,2 with the FIFO empty on alternate cycles.
        gap_en = 1'b1;
        push4(8'd5, 8'hFD, 8'd7, 8'd2);
        n_rd = 0;
        fire(2'd0, 3'd0, 2'd0, lat);
        check("load_read_count", n_rd, 4);
        gap_en = 1'b0;

        fire(2'd1, 3'd4, 2'd0, lat);
        check("sum_latency", lat, 5);
        check("sum_result", int'($signed(data_out)), 11);

        n_wr = 0;
        fire(2'd2, 3'd0, 2'd0, lat);
        check("output_write_count", n_wr, 1);
        check("output_latency", lat, 2);
        check("output_data", int'($signed(data_out)), 11);

        fire(2'd1, 3'd2, 2'd1, lat);
        check("max_l2_result", int'($signed(data_out)), 5);
        check("max_l2_latency", lat, 3);
        fire(2'd1, 3'd0, 2'd2, lat);
        check("min_l0_result", int'($signed(data_out)), -3);
        fire(2'd1, 3'd7, 2'd3, lat);
        check("abssum_l7_result", int'($signed(data_out)), 17);
        check("abssum_l7_latency", lat, 5);

        // Saturation corners.
        push4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        fire(2'd0, 3'd0, 2'd0, lat);
        fire(2'd1, 3'd4, 2'd0, lat);
        check("sat_pos_sum", int'($signed(data_out)), 127);
        push4(8'h80, 8'h80, 8'h80, 8'h80);
        fire(2'd0, 3'd0, 2'd0, lat);
        fire(2'd1, 3'd4, 2'd0, lat);
        check("sat_neg_sum", int'($signed(data_out)), -128);
        fire(2'd1, 3'd4, 2'd3, lat);
        check("sat_abssum", int'($signed(data_out)), 127);

        // OUTPUT with the output FIFO full for the first 3 OUTPUT cycles.
        n_wr = 0;
        full_left = 4;
        fire(2'd2, 3'd0, 2'd0, lat);
        check("full_stall_latency", lat, 5);
        check("full_stall_writes", n_wr, 1);

        // Invalid mode leaves memory and result alone.
        n_err = 0;
        fire(2'd3, 3'd4, 2'd0, lat);
        check("invalid_err_count", n_err, 1);
        check("invalid_latency", lat, 1);
        check("invalid_result_kept", int'($signed(data_out)), 127);
        fire(2'd1, 3'd4, 2'd0, lat);
        check("invalid_mem_kept", int'($signed(data_out)), -128);

        // Reset in the middle of a LOAD after two reads.
        push4(8'd9, 8'd9, 8'd9, 8'd9);
        n_rd = 0;
        @(posedge clk);
        #2;
        start_in = 1'b1;
        next_mode_in = 2'd0;
        @(posedge clk);
        #2;
        start_in = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (n_rd >= 2) break;
        end
        check("mid_load_reads_seen", n_rd, 2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_rd", int'(rd_in_data_fifo), 0);
        check("midreset_done", int'(done_out), 0);
        check("midreset_data_out", int'(data_out), 0);
        @(posedge clk);
        #2;
        check("midreset_held_done", int'(done_out), 0);
        fifo_q.delete();
        rst = 1'b1;
        push4(8'd1, 8'd2, 8'd3, 8'd4);
        n_rd = 0;
        fire(2'd0, 3'd0, 2'd0, lat);
        check("post_reset_reads", n_rd, 4);
        fire(2'd1, 3'd4, 2'd0, lat);
        check("post_reset_sum", int'($signed(data_out)), 10);

        // Randomised firings with FIFO gaps, full back-pressure and stray start pulses.
        rand_gap = 1'b1;
        rand_full = 1'b1;
        noise_en = 1'b1;
        for (int it = 0; it < 150; it++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            if ((m == 2'd0) && (fifo_q.size() < 4)) begin
                push4(rand_token(), rand_token(), rand_token(), rand_token());
            end
            fire(m, 3'($urandom), 2'($urandom), lat);
        end
        rand_gap = 1'b0;
        rand_full = 1'b0;
        noise_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/window_firing_fsm_v2.md
Name: window_firing_fsm_v2

Overview:
- Parametrised successor to the window-computation level-2 firing-state FSM.
- Executes one CFDF mode per `start_in`:
  - LOAD: consumes SIZE tokens from the data FIFO into local memory.
  - COMP: reduces the first L stored tokens with a selectable operation.
  - OUTPUT: writes the held result to the output FIFO.
- Compared with the previous generation, it adds:
  - FIFO empty/full back-pressure.
  - Runtime window length up to SIZE, and four reduction commands.
  - Saturating signed arithmetic and an invalid-mode error flag.
- It sits under the invoke module's firing state and returns `done_out` to that parent FSM.

Parameters:
- SIZE, 3: tokens per input vector and local-memory depth; must be >= 1.
- WIDTH, 10: signed token/result bit width; must be >= 2.
- LW, clog2(SIZE+1): width of `length_in`; derived, not overridden.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-low.
- start_in, input, 1: one-cycle fire request from the parent FSM; sampled only in START.
- next_mode_in, input, 2: mode select. 0 = LOAD, 1 = COMP, 2 = OUTPUT, 3 = invalid.
- length_in, input, LW: window length L; latched at dispatch.
- command_in, input, 2: reduction op. 0 = sum, 1 = max, 2 = min, 3 = sum of absolute values; latched at dispatch.
- data_in_fifo, input, WIDTH: first-word-fall-through head of the input FIFO; valid whenever `in_fifo_empty` = 0.
- in_fifo_empty, input, 1: input FIFO empty flag.
- out_fifo_full, input, 1: output FIFO full flag.
- rd_in_data_fifo, output, 1: input FIFO read enable.
- wr_out_fifo1, output, 1: output FIFO write enable.
- data_out, output, WIDTH: result register value.
- done_out, output, 1: one-cycle completion pulse to the parent FSM.
- err_out, output, 1: one-cycle pulse indicating an invalid mode.

Behaviour:
- Reset (async, `rst` = 0):
  - State goes to START; index counter, accumulator and result register go to 0; local memory is cleared to 0.
  - All outputs are 0.
  - Reset mid-operation abandons the mode; no `done_out` is produced for it.
- States: START, LOAD, COMP, OUTPUT, END. All outputs are Moore-style except the two FIFO enables, which are gated combinationally by the flags.
- START:
  - If `start_in` = 1, latch `length_in` and `command_in`, clear the index counter, and branch on `next_mode_in`:
    - 0 goes to LOAD.
    - 1 goes to COMP; the accumulator is initialised per command.
    - 2 goes to OUTPUT.
    - 3 goes to END, with `err_out` = 1 during that END cycle.
  - Otherwise remain in START.
- LOAD:
  - `rd_in_data_fifo` = !`in_fifo_empty`.
  - On each edge where the read is asserted: `mem[idx]` <= `data_in_fifo`, then `idx`++.
  - After the SIZE-th read, go to END.
  - While the FIFO is empty, stall with no read and no state change.
- COMP:
  - Effective length Le = SIZE if L = 0 or L > SIZE; otherwise Le = L.
  - One element per cycle for Le cycles, over `mem[0..Le-1]`.
  - Accumulator is WIDTH+clog2(SIZE)+1 bits, signed. Initial value is 0 for sum/abs-sum, and the first element for max/min.
  - Max/min use signed compare.
  - abs(most-negative) is computed in the wide accumulator, so it does not overflow.
  - On the last element: result <= accumulator saturated to the signed WIDTH range; then go to END.
  - Latency from dispatch: Le cycles in COMP plus 1 END cycle.
- OUTPUT:
  - `wr_out_fifo1` = !`out_fifo_full`.
  - `data_out` always shows the result register.
  - On the write edge, go to END.
  - While full, stall with no write.
  - The result is not cleared by OUTPUT; repeated OUTPUT firings rewrite the same value.
- END: `done_out` = 1 for exactly one cycle, then go to START. The next `start_in` is accepted in START only, so back-to-back firings occur at most every other cycle.
- Mode isolation:
  - LOAD does not alter the result.
  - COMP does not read the FIFO.
  - An invalid mode changes neither memory nor result.
- `start_in` asserted outside START is ignored.

Decomposition:
- Shared package `window_pkg`:
  - Mode codes: MODE_LOAD, MODE_COMP, MODE_OUTPUT.
  - Command codes: CMD_SUM, CMD_MAX, CMD_MIN, CMD_ABSSUM.
  - State encoding localparams.
  - clog2 function (returns 1 for an input of 1).
- One sub-module, `window_reduce_step`: combinational; takes (accumulator, element, command, first-flag) and returns the next accumulator, plus a saturate-to-WIDTH helper output.
- Memory, counter and FSM remain in the top module.

Test Plan (SIZE=4, WIDTH=8):
- LOAD with FIFO contents 5, -3, 7, 2 and `in_fifo_empty` high on alternate cycles -> exactly 4 `rd_in_data_fifo` pulses, each only while empty = 0; `done_out` pulses one cycle after the 4th read.
- COMP with cmd=sum, L=4, then OUTPUT -> `data_out` = 11, one `wr_out_fifo1` pulse; COMP-to-`done_out` takes 5 cycles.
- COMP with cmd=max, L=2 -> result 5. COMP with cmd=min, L=0 (treated as 4) -> result -3. COMP with cmd=abssum, L=7 (clamped to 4) -> result 17.
- Saturation:
  - LOAD 127 ×4, cmd=sum -> 127.
  - LOAD -128 ×4, cmd=sum -> -128.
  - LOAD -128 ×4, cmd=abssum -> 127.
- OUTPUT with `out_fifo_full` = 1 for 3 cycles -> no write during those cycles; write on the 4th cycle; `done_out` on the next cycle.
- Mode 3 -> `err_out` and `done_out` pulse together, with memory and result unchanged.
- Reset asserted during LOAD after 2 reads -> immediate START with all outputs 0; a following full LOAD reads 4 new tokens.
